// File: rtl/supervisor.sv
// Supervisor for one node: sources argument/error, sinks result/propagate, one sample in flight.
// 3 cycles/sample in inference, 5 in training; every valid/ready is decoded from registered state.
module supervisor #(
  parameter int N = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              train,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [16+N*8-1:0] sample_data,
  output logic              argument_valid,
  input  logic              argument_ready,
  output logic [N*8-1:0]    argument_data,
  input  logic              result_valid,
  output logic              result_ready,
  input  logic [15:0]       result_data,
  output logic              error_valid,
  input  logic              error_ready,
  output logic [15:0]       error_data,
  input  logic              propagate_valid,
  output logic              propagate_ready,
  output logic [15:0]       count,
  output logic [15:0]       last_error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARG  = 3'd1;
  localparam logic [2:0] S_RES  = 3'd2;
  localparam logic [2:0] S_ERR  = 3'd3;
  localparam logic [2:0] S_PRP  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic           train_q, train_d;
  logic [15:0]    target_q, target_d;
  logic [N*8-1:0] argument_q, argument_d;
  logic [15:0]    err_q, err_d;
  logic [15:0]    count_q, count_d;

  logic [16:0]    diff;
  logic [15:0]    err_sat;

  // 17-bit difference cannot wrap; a sign mismatch between bits 16 and 15 means overflow.
  always_comb begin
    diff = {target_q[15], target_q} - {result_data[15], result_data};
    if (diff[16] != diff[15]) begin
      err_sat = diff[16] ? 16'h8000 : 16'h7fff;
    end else begin
      err_sat = diff[15:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    train_d    = train_q;
    target_d   = target_q;
    argument_d = argument_q;
    err_d      = err_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          train_d    = train;
          target_d   = sample_data[16+N*8-1 -: 16];
          argument_d = sample_data[N*8-1:0];
          state_d    = S_ARG;
        end
      end
      S_ARG: begin
        if (argument_ready) begin
          state_d = S_RES;
        end
      end
      S_RES: begin
        if (result_valid) begin
          err_d = err_sat;
          if (train_q) begin
            state_d = S_ERR;
          end else begin
            count_d = count_q + 16'd1;
            state_d = S_IDLE;
          end
        end
      end
      S_ERR: begin
        if (error_ready) begin
          state_d = S_PRP;
        end
      end
      S_PRP: begin
        if (propagate_valid) begin
          count_d = count_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      train_q    <= 1'b0;
      target_q   <= 16'h0000;
      argument_q <= '0;
      err_q      <= 16'h0000;
      count_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      train_q    <= train_d;
      target_q   <= target_d;
      argument_q <= argument_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign sample_ready    = (state_q == S_IDLE);
  assign argument_valid  = (state_q == S_ARG);
  assign result_ready    = (state_q == S_RES);
  assign error_valid     = (state_q == S_ERR);
  assign propagate_ready = (state_q == S_PRP);

  // error_data and last_error are always loaded together, so one register feeds both.
  assign argument_data = argument_q;
  assign error_data    = err_q;
  assign last_error    = err_q;
  assign count         = count_q;

endmodule

// File: tb/tb_supervisor.sv
module tb_supervisor;

  logic        clock;
  logic        reset;
  logic        train;
  logic        sample_valid;
  logic        sample_ready;
  logic [31:0] sample_data;
  logic        argument_valid;
  logic        argument_ready;
  logic [15:0] argument_data;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] result_data;
  logic        error_valid;
  logic        error_ready;
  logic [15:0] error_data;
  logic        propagate_valid;
  logic        propagate_ready;
  logic [15:0] count;
  logic [15:0] last_error;

  supervisor #(.N(2)) dut (
    .clock(clock), .reset(reset), .train(train),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .argument_valid(argument_valid), .argument_ready(argument_ready), .argument_data(argument_data),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
    .error_valid(error_valid), .error_ready(error_ready), .error_data(error_data),
    .propagate_valid(propagate_valid), .propagate_ready(propagate_ready),
    .count(count), .last_error(last_error)
  );

  typedef struct {
    logic [15:0] arg;
    logic [15:0] err;
    logic        tr;
    logic [15:0] cnt;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          fails = 0;
  int          cyc = 0;
  int          arg_stall = 0;
  int          err_stall = 0;
  int          arg_wait = 0;
  int          err_wait = 0;
  int          start_cyc = 0;
  bit          in_flight = 0;
  bit          res_seen = 0;
  bit          saw_err = 0;
  logic [15:0] exp_count = 16'h0000;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Node model: accepts/answers one cycle after the request, optionally stalling.
  initial begin
    argument_ready  = 1'b0;
    error_ready     = 1'b0;
    result_valid    = 1'b1;
    propagate_valid = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      arg_wait       = argument_valid ? arg_wait + 1 : 0;
      err_wait       = error_valid ? err_wait + 1 : 0;
      argument_ready = argument_valid && (arg_wait > arg_stall);
      error_ready    = error_valid && (err_wait > err_stall);
    end
  end

  // Monitor: compares DUT outputs against the head of the expectation queue.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        in_flight = 0;
        res_seen  = 0;
      end else begin
        if (res_seen) begin
          res_seen = 0;
          if (exp_q.size() > 0) begin
            check("last_error", 32'(last_error), 32'(exp_q[0].err));
            check("error_valid_after_result", 32'(error_valid), 32'(exp_q[0].tr));
          end
        end
        if (in_flight && sample_ready) begin
          in_flight = 0;
          if (exp_q.size() > 0) begin
            check("count", 32'(count), 32'(exp_q[0].cnt));
            check("error_handshake_seen", 32'(saw_err), 32'(exp_q[0].tr));
            if (exp_q[0].cycles != 0) check("loop_cycles", cyc - start_cyc, exp_q[0].cycles);
            void'(exp_q.pop_front());
          end
        end
        if (sample_valid && sample_ready) begin
          in_flight = 1;
          start_cyc = cyc;
          saw_err   = 0;
          check("expectations_queued", exp_q.size(), 1);
        end
        if (argument_valid && exp_q.size() > 0)
          check("argument_data", 32'(argument_data), 32'(exp_q[0].arg));
        if (error_valid && exp_q.size() > 0) begin
          check("error_data", 32'(error_data), 32'(exp_q[0].err));
          if (error_ready) saw_err = 1;
        end
        if (result_valid && result_ready) res_seen = 1;
      end
    end
  end

  task automatic issue(input logic tr, input logic [15:0] tgt, input logic [15:0] arg,
                       input logic [15:0] res, input logic [15:0] err,
                       input int as, input int es, input int cycles);
    exp_t e;
    int   n;
    exp_count = exp_count + 16'd1;
    e = '{arg, err, tr, exp_count, cycles};
    exp_q.push_back(e);
    arg_stall   = as;
    err_stall   = es;
    result_data = res;
    @(posedge clock);
    #1;
    train        = tr;
    sample_data  = {tgt, arg};
    sample_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!sample_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("sample_accepted", 32'(sample_ready), 32'd1);
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
    sample_data  = $urandom;
    train        = ~tr;
  endtask

  task automatic finish_wait();
    int n;
    n = 0;
    while ((in_flight || exp_q.size() != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("sample_completed", exp_q.size(), 0);
  endtask

  task automatic run(input logic tr, input logic [15:0] tgt, input logic [15:0] arg,
                     input logic [15:0] res, input logic [15:0] err,
                     input int as, input int es, input int cycles);
    issue(tr, tgt, arg, res, err, as, es, cycles);
    finish_wait();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset        = 1'b1;
    train        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 32'h0;
    result_data  = 16'h0;
    #2;
    check("reset_handshakes", 32'({sample_ready, argument_valid, result_ready, error_valid, propagate_ready}), 32'b10000);
    check("reset_argument_data", 32'(argument_data), 32'h0);
    check("reset_error_data", 32'(error_data), 32'h0);
    check("reset_count", 32'(count), 32'h0);
    check("reset_last_error", 32'(last_error), 32'h0);
    @(posedge clock);
    #2;
    reset = 1'b0;

    //  train tgt       arg       result    error    astl estl cycles
    run(1'b1, 16'hff00, 16'h00ff, 16'h0010, 16'hfef0, 0, 0, 5);
    run(1'b1, 16'h7fff, 16'h1234, 16'h8000, 16'h7fff, 0, 0, 5);
    run(1'b1, 16'h8000, 16'habcd, 16'h0001, 16'h8000, 0, 0, 5);
    run(1'b0, 16'h0100, 16'h0102, 16'h0080, 16'h0080, 0, 0, 3);
    run(1'b1, 16'h0200, 16'h5a5a, 16'h0300, 16'hff00, 3, 4, 12);
    run(1'b0, 16'h8000, 16'h0001, 16'h7fff, 16'h8000, 0, 0, 3);
    run(1'b0, 16'h7fff, 16'h7e7e, 16'hff00, 16'h7fff, 0, 0, 3);

    // Reset while the node holds off the error transfer.
    issue(1'b1, 16'h0100, 16'h3344, 16'h0020, 16'h00e0, 0, 30, 0);
    n = 0;
    while (!error_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("error_valid_before_reset", 32'(error_valid), 32'd1);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_handshakes", 32'({sample_ready, argument_valid, result_ready, error_valid, propagate_ready}), 32'b10000);
    check("async_reset_count", 32'(count), 32'h0);
    check("async_reset_error_data", 32'(error_data), 32'h0);
    check("async_reset_argument_data", 32'(argument_data), 32'h0);
    exp_q.delete();
    exp_count = 16'h0000;
    err_stall = 0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    run(1'b1, 16'h0010, 16'h0000, 16'h0020, 16'hfff0, 0, 0, 5);

    // Count wrap: jump the counter to its last value instead of running 65535 samples.
    force dut.count_q = 16'hffff;
    @(posedge clock);
    @(negedge clock);
    release dut.count_q;
    #1;
    check("count_preload", 32'(count), 32'hffff);
    exp_count = 16'hffff;
    run(1'b1, 16'h0040, 16'h0001, 16'h0001, 16'h003f, 0, 0, 5);
    run(1'b0, 16'h0003, 16'h0203, 16'h0005, 16'hfffe, 0, 0, 3);

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/supervisor.md
# supervisor

Drives a single `node` as the far end of its four streams: it sources `argument`, sinks `result`, computes the training error against a target, sources `error`, and sinks `propagate`. It sits between a sample source (memory or host FIFO) and the output-layer node, doing in hardware the forward/backward sequencing a bench otherwise does. One sample is in flight at a time, so the node's handshake ordering is never violated.

## Interface
- `N`, 2, number of node arguments.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `train`  in  1  training enable; sampled only when a sample is accepted.
- `sample_valid`  in  1  sample available.
- `sample_ready`  out  1  supervisor idle, can accept a sample.
- `sample_data`  in  16+N*8  `{target[15:0], argument[N-1:0][7:0]}`; target is signed Q8.8.
- `argument_valid`  out  1  to node.
- `argument_ready`  in  1  from node.
- `argument_data`  out  N*8  latched argument.
- `result_valid`  in  1  from node.
- `result_ready`  out  1  to node.
- `result_data`  in  16  node output, signed Q8.8.
- `error_valid`  out  1  to node.
- `error_ready`  in  1  from node.
- `error_data`  out  16  saturated target − result.
- `propagate_valid`  in  1  from node.
- `propagate_ready`  out  1  to node; propagate data is consumed and discarded.
- `count`  out  16  samples completed, wraps.
- `last_error`  out  16  most recent computed error, updated in both modes.

## Operation
- A transfer occurs on a rising edge when valid and ready are both high.
- FSM states: IDLE, ARG, RES, ERR, PRP.
  - IDLE: `sample_ready=1`. On a sample transfer, latch target, argument, and `train`, then go to ARG.
  - ARG: `argument_valid=1`. On transfer, go to RES.
  - RES: `result_ready=1`. On transfer, compute error and load `error_data` and `last_error`.
    - If latched train is 1, go to ERR.
    - If latched train is 0, increment `count` and go to IDLE.
  - ERR: `error_valid=1`. On transfer, go to PRP.
  - PRP: `propagate_ready=1`. On transfer, increment `count` and go to IDLE.
- Error arithmetic:
  - Compute e = sext17(target) − sext17(result).
  - If e > 32767, output 16'h7fff.
  - If e < −32768, output 16'h8000.
  - Otherwise output e[15:0].
- `count` wraps from 16'hffff to 0.
- `train` changing mid-sample has no effect until the next sample.
- Each valid/ready output is high only in its own state, so at most one is asserted at a time.
- Latched data on `argument_data` and `error_data` is stable while the corresponding valid is high.

## Timing
- All valid/ready outputs decode directly from registered state; there is no combinational path from any input to any output.
- Sample accepted at edge T: `argument_valid` is high from T+1.
- Result accepted at edge R: `error_valid` is high and `error_data` and `last_error` are valid from R+1.
- With zero backpressure and node responses arriving in the cycle after the request:
  - Inference loop is 3 cycles per sample.
  - Training loop is 5 cycles per sample.
- Back-to-back: `sample_ready` is high in the cycle after the final transfer of the previous sample.
- Reset values, asserted asynchronously at any time including mid-sample:
  - State IDLE.
  - `sample_ready=1`.
  - `argument_valid`, `result_ready`, `error_valid`, `propagate_ready` all 0.
  - `argument_data`, `error_data`, `count`, `last_error` all 0.
- A sample interrupted by reset is dropped and is not counted.

## Test plan
- Training, no backpressure: train=1, sample {16'hff00, 16'h00ff}; node returns result 16'h0010 → `argument_data`=16'h00ff, `error_data`=16'hfef0, propagate accepted, `count`=1, 5-cycle loop.
- Saturation:
  - target 16'h7fff, result 16'h8000 → `error_data`=16'h7fff.
  - target 16'h8000, result 16'h0001 → `error_data`=16'h8000.
- Inference: train=0, target 16'h0100, result 16'h0080 → no `error_valid` pulse, `last_error`=16'h0080, `count` increments one cycle after the result transfer.
- Backpressure: hold `argument_ready` low 3 cycles, then `error_ready` low 4 cycles → valids stay high and data stays stable throughout; exactly one transfer each; `count` +1.
- Reset mid-operation: assert reset while in ERR → `error_valid` drops without waiting for a clock edge and `count`=0. After release, the next sample completes normally with `count`=1.
- Wrap and train latching: preload 65535 samples, then run one more → `count` 16'hffff→16'h0000. Toggle `train` 1→0 in RES → ERR and PRP are still executed for that sample.
